ysyx_22050019_axi_rd_slave: RTL

YSYX_22050019_AXI_RD_SLAVE -- requirements
Module: ysyx_22050019_axi_rd_slave

---
 rtl/ysyx_22050019_axi_rd_slave.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ysyx_22050019_axi_rd_slave.sv
// AXI read-only slave backed by a preloadable word memory.
// Serves one INCR burst at a time with a fixed access latency; out-of-range beats return DECERR.
module ysyx_22050019_axi_rd_slave #(
  parameter int unsigned             ADDR_WIDTH = 32,
  parameter int unsigned             DATA_WIDTH = 64,
  parameter int unsigned             MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned             LATENCY    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ar_valid_i,
  output logic                    ar_ready_o,
  input  logic [ADDR_WIDTH-1:0]   ar_addr_i,
  input  logic [7:0]              ar_len_i,
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  output logic [DATA_WIDTH-1:0]   r_data_o,
  output logic [1:0]              r_resp_o,
  output logic                    r_last_o,
  input  logic                    mem_wen_i,
  input  logic [ADDR_WIDTH-1:0]   mem_waddr_i,
  input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] mem_wstrb_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  localparam int unsigned IdxW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned StrbW = DATA_WIDTH / 8;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            beat_q, beat_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [1:0]            resp_q;
  logic                  last_q;

  logic                  load;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [7:0]            load_beat, load_len;
  logic                  load_in;
  logic [DATA_WIDTH-1:0] load_word;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ((off >> 3) < ADDR_WIDTH'(MEM_DEPTH));
  endfunction

  function automatic logic [IdxW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return IdxW'(off >> 3);
  endfunction

  assign ar_ready_o = !rst && (state_q == IDLE);
  assign r_valid_o  = !rst && (state_q == DATA);
  assign r_data_o   = rst ? '0 : data_q;
  assign r_resp_o   = rst ? 2'b00 : resp_q;
  assign r_last_o   = !rst && last_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    beat_d    = beat_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    load_addr = addr_q;
    load_beat = beat_q;
    load_len  = len_q;
    unique case (state_q)
      IDLE: begin
        if (ar_valid_i && ar_ready_o) begin
          addr_d = ar_addr_i & ~ADDR_WIDTH'(7);
          len_d  = ar_len_i;
          beat_d = 8'd0;
          if (LATENCY == 0) begin
            state_d   = DATA;
            load      = 1'b1;
            load_addr = ar_addr_i & ~ADDR_WIDTH'(7);
            load_beat = 8'd0;
            load_len  = ar_len_i;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = DATA;
          load    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DATA: begin
        if (r_ready_i) begin
          if (beat_q == len_q) begin
            state_d = IDLE;
          end else begin
            addr_d    = addr_q + ADDR_WIDTH'(8);
            beat_d    = beat_q + 8'd1;
            load      = 1'b1;
            load_addr = addr_q + ADDR_WIDTH'(8);
            load_beat = beat_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Array read sees the pre-edge contents, so a same-edge preload write is not visible here.
  assign load_in   = in_range(load_addr);
  assign load_word = load_in ? mem[word_idx(load_addr)] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      resp_q  <= 2'b00;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      if (load) begin
        data_q <= load_word;
        resp_q <= load_in ? 2'b00 : 2'b11;
        last_q <= (load_beat == load_len);
      end
    end
  end

  // Backing store is deliberately outside reset.
  always_ff @(posedge clk) begin
    if (mem_wen_i && in_range(mem_waddr_i)) begin
      for (int b = 0; b < StrbW; b++) begin
        if (mem_wstrb_i[b]) mem[word_idx(mem_waddr_i)][b*8 +: 8] <= mem_wdata_i[b*8 +: 8];
      end
    end
  end

endmodule
